// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Purpose  : ID/EX pipeline register with valid bit, hold, flush, load-use
//            bubble insertion and a saturating bubble counter.
// Revision : 1.0
// ============================================================================
module id_ex_stage_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int CTRL_W      = 10,
    parameter int MEMREAD_BIT = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              uses_rt_in,
    input  logic [DATA_W-1:0] next_pc_in,
    input  logic [DATA_W-1:0] read_data1_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [DATA_W-1:0] sign_ext_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              hold,
    input  logic              flush,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] next_pc_out,
    output logic [DATA_W-1:0] read_data1_out,
    output logic [DATA_W-1:0] read_data2_out,
    output logic [DATA_W-1:0] sign_ext_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              hazard,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_next_pc;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_sext;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_bubbles;

    logic w_hazard;
    logic w_rt_match;

    // A load in EX whose destination ($rt, never $zero) feeds the ID instruction.
    assign w_rt_match = (r_rt == rs_in) | (uses_rt_in & (r_rt == rt_in));
    assign w_hazard   = r_valid & r_ctrl[MEMREAD_BIT] & (r_rt != '0) & valid_in & w_rt_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_next_pc <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_sext    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_bubbles <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (hold) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            // Bubble: payload is left stale; zero control keeps it harmless.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (r_bubbles != c_CNT_MAX) begin
                r_bubbles <= r_bubbles + 1'b1;
            end
        end else begin
            r_valid   <= valid_in;
            r_ctrl    <= valid_in ? ctrl_in : '0;
            r_next_pc <= next_pc_in;
            r_rd1     <= read_data1_in;
            r_rd2     <= read_data2_in;
            r_sext    <= sign_ext_in;
            r_rs      <= rs_in;
            r_rt      <= rt_in;
            r_rd      <= rd_in;
        end
    end

    assign valid_out      = r_valid;
    assign ctrl_out       = r_ctrl;
    assign next_pc_out    = r_next_pc;
    assign read_data1_out = r_rd1;
    assign read_data2_out = r_rd2;
    assign sign_ext_out   = r_sext;
    assign rs_out         = r_rs;
    assign rt_out         = r_rt;
    assign rd_out         = r_rd;
    assign hazard         = w_hazard;
    assign stall_id       = w_hazard | hold;
    assign bubble_count   = r_bubbles;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Purpose  : Directed self-checking bench for id_ex_stage_reg.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst, rst_s;
    logic        valid_in, uses_rt_in, hold, flush;
    logic [9:0]  ctrl_in;
    logic [31:0] next_pc_in, read_data1_in, read_data2_in, sign_ext_in;
    logic [4:0]  rs_in, rt_in, rd_in;

    logic        valid_out, hazard, stall_id;
    logic [9:0]  ctrl_out;
    logic [31:0] next_pc_out, read_data1_out, read_data2_out, sign_ext_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [15:0] bubble_count;

    logic        s_valid_out, s_hazard, s_stall_id;
    logic [9:0]  s_ctrl_out;
    logic [31:0] s_next_pc_out, s_rd1_out, s_rd2_out, s_sext_out;
    logic [4:0]  s_rs_out, s_rt_out, s_rd_out;
    logic [1:0]  s_bubble_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .uses_rt_in(uses_rt_in), .next_pc_in(next_pc_in),
        .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
        .sign_ext_in(sign_ext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .hold(hold), .flush(flush), .valid_out(valid_out), .ctrl_out(ctrl_out),
        .next_pc_out(next_pc_out), .read_data1_out(read_data1_out),
        .read_data2_out(read_data2_out), .sign_ext_out(sign_ext_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .hazard(hazard),
        .stall_id(stall_id), .bubble_count(bubble_count)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst_s), .valid_in(valid_in), .ctrl_in(ctrl_in),
        .uses_rt_in(uses_rt_in), .next_pc_in(next_pc_in),
        .read_data1_in(read_data1_in), .read_data2_in(read_data2_in),
        .sign_ext_in(sign_ext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .hold(hold), .flush(flush), .valid_out(s_valid_out), .ctrl_out(s_ctrl_out),
        .next_pc_out(s_next_pc_out), .read_data1_out(s_rd1_out),
        .read_data2_out(s_rd2_out), .sign_ext_out(s_sext_out),
        .rs_out(s_rs_out), .rt_out(s_rt_out), .rd_out(s_rd_out), .hazard(s_hazard),
        .stall_id(s_stall_id), .bubble_count(s_bubble_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an ID instruction to the stage.
    task automatic id_instr(input logic [9:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urt, input logic [31:0] rd1);
        valid_in      = 1'b1;
        ctrl_in       = ctrl;
        rs_in         = rs;
        rt_in         = rt;
        rd_in         = 5'd0;
        uses_rt_in    = urt;
        read_data1_in = rd1;
        read_data2_in = 32'h0;
        sign_ext_in   = 32'h0;
        next_pc_in    = 32'h0;
    endtask

    localparam logic [9:0] LW  = 10'h0A6;
    localparam logic [9:0] ADD = 10'h241;

    initial begin
        // Reset with every input driven high
        rst = 1'b1; rst_s = 1'b1;
        valid_in = 1'b1; uses_rt_in = 1'b1; hold = 1'b1; flush = 1'b1;
        ctrl_in = '1; next_pc_in = '1; read_data1_in = '1; read_data2_in = '1;
        sign_ext_in = '1; rs_in = '1; rt_in = '1; rd_in = '1;
        step();
        step();
        hold = 1'b0; flush = 1'b0;
        #1;
        check("rst_valid",  {31'd0, valid_out}, 32'd0);
        check("rst_ctrl",   {22'd0, ctrl_out}, 32'd0);
        check("rst_rd1",    read_data1_out, 32'd0);
        check("rst_npc",    next_pc_out, 32'd0);
        check("rst_rt",     {27'd0, rt_out}, 32'd0);
        check("rst_bubble", {16'd0, bubble_count}, 32'd0);
        check("rst_stall",  {31'd0, stall_id}, 32'd0);
        check("rst_bubble_s", {30'd0, s_bubble_count}, 32'd0);
        rst = 1'b0; rst_s = 1'b0;

        // Straight load
        id_instr(10'h041, 5'd3, 5'd9, 1'b1, 32'h12345678);
        step();
        check("load_valid", {31'd0, valid_out}, 32'd1);
        check("load_ctrl",  {22'd0, ctrl_out}, 32'h041);
        check("load_rd1",   read_data1_out, 32'h12345678);
        check("load_rt",    {27'd0, rt_out}, 32'd9);
        check("load_haz",   {31'd0, hazard}, 32'd0);

        // Load-use: lw $9 then add rs=$9
        id_instr(LW, 5'd4, 5'd9, 1'b0, 32'h11110000);
        step();
        check("lw_ctrl", {22'd0, ctrl_out}, {22'd0, LW});
        id_instr(ADD, 5'd9, 5'd10, 1'b1, 32'hAAAA0001);
        #1;
        check("lu_hazard", {31'd0, hazard}, 32'd1);
        check("lu_stall",  {31'd0, stall_id}, 32'd1);
        step();
        check("bub_valid",  {31'd0, valid_out}, 32'd0);
        check("bub_ctrl",   {22'd0, ctrl_out}, 32'd0);
        check("bub_count",  {16'd0, bubble_count}, 32'd1);
        check("bub_rd1",    read_data1_out, 32'h11110000);
        check("bub_haz",    {31'd0, hazard}, 32'd0);
        step();
        check("add_valid", {31'd0, valid_out}, 32'd1);
        check("add_ctrl",  {22'd0, ctrl_out}, {22'd0, ADD});
        check("add_rd1",   read_data1_out, 32'hAAAA0001);
        check("add_count", {16'd0, bubble_count}, 32'd1);

        // $zero destination never hazards
        id_instr(LW, 5'd1, 5'd0, 1'b0, 32'h0);
        step();
        id_instr(ADD, 5'd0, 5'd0, 1'b1, 32'h0);
        #1;
        check("zero_haz", {31'd0, hazard}, 32'd0);

        // uses_rt qualification
        id_instr(LW, 5'd1, 5'd9, 1'b0, 32'h33330000);
        step();
        id_instr(ADD, 5'd1, 5'd9, 1'b0, 32'h0);
        #1;
        check("nort_haz", {31'd0, hazard}, 32'd0);
        uses_rt_in = 1'b1;
        #1;
        check("rt_haz", {31'd0, hazard}, 32'd1);

        // Flush beats hazard
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_valid", {31'd0, valid_out}, 32'd0);
        check("flush_ctrl",  {22'd0, ctrl_out}, 32'd0);
        check("flush_count", {16'd0, bubble_count}, 32'd1);
        check("flush_rd1",   read_data1_out, 32'h33330000);

        // Hold beats hazard for three cycles
        id_instr(LW, 5'd2, 5'd9, 1'b0, 32'h22220000);
        step();
        id_instr(ADD, 5'd9, 5'd3, 1'b1, 32'h44440000);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", {31'd0, valid_out}, 32'd1);
            check("hold_ctrl",  {22'd0, ctrl_out}, {22'd0, LW});
            check("hold_rd1",   read_data1_out, 32'h22220000);
            check("hold_stall", {31'd0, stall_id}, 32'd1);
            check("hold_haz",   {31'd0, hazard}, 32'd1);
            check("hold_count", {16'd0, bubble_count}, 32'd1);
        end
        hold = 1'b0;
        step();
        check("post_hold_valid", {31'd0, valid_out}, 32'd0);
        check("post_hold_count", {16'd0, bubble_count}, 32'd2);
        step();
        check("post_hold_add", read_data1_out, 32'h44440000);

        // Saturation on the 2-bit counter instance
        rst_s = 1'b1;
        id_instr(10'h000, 5'd0, 5'd0, 1'b0, 32'h0);
        valid_in = 1'b0;
        step();
        rst_s = 1'b0;
        check("sat_rst", {30'd0, s_bubble_count}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            id_instr(LW, 5'd1, 5'd9, 1'b0, 32'h0);
            step();
            id_instr(ADD, 5'd9, 5'd2, 1'b1, 32'h0);
            step();
            check("sat_count", {30'd0, s_bubble_count}, (i < 3) ? (i + 1) : 3);
        end
        check("nosat_count", {16'd0, bubble_count}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
